// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: accepts one padded 512-bit block and streams
// Wt/Kt for rounds 0..63, framed by soc/eoc strobes for the compression stage.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   blk_in     padded block, big-endian (W0 = blk_in[511:480])
//   blk_valid  blk_in is valid
//   blk_ready  block can be accepted this cycle (IDLE and not in reset)
//   wt, kt     schedule word and round constant for the current round
//   round      current round index
//   soc        high during round 0
//   eoc        high for the single cycle after round 63
//   busy       high while streaming or signalling eoc
module sha256_msg_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] blk_in,
    input  logic         blk_valid,
    output logic         blk_ready,
    output logic [31:0]  wt,
    output logic [31:0]  kt,
    output logic [5:0]   round,
    output logic         soc,
    output logic         eoc,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [31:0] K_ROM [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t      state_q;
    logic [31:0] w_q [16];
    logic [5:0]  round_q;
    logic [31:0] w15_d;

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Window holds W[t..t+15]; the new tail word is W[t+16].
    assign w15_d = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

    assign blk_ready = (state_q == IDLE) && !rst;
    assign wt        = (state_q == RUN) ? w_q[0] : 32'h0;
    assign kt        = (state_q == RUN) ? K_ROM[round_q] : 32'h0;
    assign soc       = (state_q == RUN) && (round_q == 6'd0);
    assign eoc       = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign round     = round_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= 6'd0;
            for (int i = 0; i < 16; i++) w_q[i] <= 32'h0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (blk_valid && blk_ready) begin
                        for (int i = 0; i < 16; i++)
                            w_q[i] <= blk_in[511-32*i -: 32];
                        round_q <= 6'd0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                    w_q[15] <= w15_d;
                    // Leave RUN explicitly rather than letting round wrap.
                    if (round_q == 6'd63) begin
                        round_q <= 6'd0;
                        state_q <= DONE;
                    end else begin
                        round_q <= round_q + 6'd1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed testbench for sha256_msg_schedule: reset, "abc" golden schedule,
// cycle timing, back-to-back acceptance, mid-run reset and full-hash check.
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] blk_in;
    logic         blk_valid;
    logic         blk_ready;
    logic [31:0]  wt, kt;
    logic [5:0]   round;
    logic         soc, eoc, busy;

    int checks = 0;
    int failures = 0;

    localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_B = {32'hdeadbeef, 32'h01234567, 448'h0};
    localparam logic [255:0] ABC_HASH =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic [31:0] gold [20];
    logic [31:0] hh [8];
    logic [31:0] va, vb, vc, vd, ve, vf, vg, vh;

    sha256_msg_schedule dut (
        .clk(clk), .rst(rst), .blk_in(blk_in), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .wt(wt), .kt(kt), .round(round),
        .soc(soc), .eoc(eoc), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic comp_init();
        hh[0] = 32'h6a09e667; hh[1] = 32'hbb67ae85;
        hh[2] = 32'h3c6ef372; hh[3] = 32'ha54ff53a;
        hh[4] = 32'h510e527f; hh[5] = 32'h9b05688c;
        hh[6] = 32'h1f83d9ab; hh[7] = 32'h5be0cd19;
        va = hh[0]; vb = hh[1]; vc = hh[2]; vd = hh[3];
        ve = hh[4]; vf = hh[5]; vg = hh[6]; vh = hh[7];
    endtask

    // One compression round driven by the DUT's wt/kt.
    task automatic comp_round(input logic [31:0] w, input logic [31:0] k);
        logic [31:0] t1, t2;
        t1 = vh + (rotr(ve, 6) ^ rotr(ve, 11) ^ rotr(ve, 25))
                + ((ve & vf) ^ (~ve & vg)) + k + w;
        t2 = (rotr(va, 2) ^ rotr(va, 13) ^ rotr(va, 22))
                + ((va & vb) ^ (va & vc) ^ (vb & vc));
        vh = vg; vg = vf; vf = ve; ve = vd + t1;
        vd = vc; vc = vb; vb = va; va = t1 + t2;
    endtask

    function automatic logic [255:0] comp_final();
        return {hh[0] + va, hh[1] + vb, hh[2] + vc, hh[3] + vd,
                hh[4] + ve, hh[5] + vf, hh[6] + vg, hh[7] + vh};
    endfunction

    task automatic test_reset();
        rst = 1'b0; blk_valid = 1'b0; blk_in = ABC;
        step();
        #3;
        rst = 1'b1; blk_valid = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            if ({blk_ready, soc, eoc, busy} !== 4'b0) begin
                failures++;
                $display("FAIL reset_ctl c=%0d: got %b exp 0000", c,
                         {blk_ready, soc, eoc, busy});
            end
            checks++;
            if ({wt, kt, round} !== 70'h0) begin
                failures++;
                $display("FAIL reset_data c=%0d: got %h %h %0d exp 0", c,
                         wt, kt, round);
            end
            checks++;
            if (c < 3) step();
        end
        #3;
        rst = 1'b0; blk_valid = 1'b0;
        step();
        if (blk_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got rdy=%b busy=%b exp 1 0",
                     blk_ready, busy);
        end
        checks++;
    endtask

    task automatic test_abc(input string tag);
        logic [255:0] hash;
        comp_init();
        blk_in = ABC; blk_valid = 1'b1;
        if (blk_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_pre: got %b exp 1", tag, blk_ready);
        end
        checks++;
        step();
        blk_valid = 1'b0;
        blk_in = BLK_B;
        for (int cyc = 1; cyc <= 66; cyc++) begin
            if (cyc <= 64) begin
                int t;
                t = cyc - 1;
                if (round !== 6'(t) || soc !== (t == 0) || busy !== 1'b1
                    || eoc !== 1'b0 || blk_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s ctl t=%0d: got r=%0d soc=%b busy=%b eoc=%b rdy=%b",
                             tag, t, round, soc, busy, eoc, blk_ready);
                end
                checks++;
                if (t < 20) begin
                    if (wt !== gold[t]) begin
                        failures++;
                        $display("FAIL %s wt t=%0d: got %h exp %h",
                                 tag, t, wt, gold[t]);
                    end
                    checks++;
                end
                if (t == 0 && kt !== 32'h428a2f98) begin
                    failures++;
                    $display("FAIL %s k0: got %h exp 428a2f98", tag, kt);
                end
                if (t == 63 && kt !== 32'hc67178f2) begin
                    failures++;
                    $display("FAIL %s k63: got %h exp c67178f2", tag, kt);
                end
                if (t == 0 || t == 63) checks++;
                comp_round(wt, kt);
            end else if (cyc == 65) begin
                if (eoc !== 1'b1 || busy !== 1'b1 || soc !== 1'b0
                    || blk_ready !== 1'b0 || wt !== 32'h0 || kt !== 32'h0) begin
                    failures++;
                    $display("FAIL %s done: got eoc=%b busy=%b soc=%b rdy=%b wt=%h kt=%h",
                             tag, eoc, busy, soc, blk_ready, wt, kt);
                end
                checks++;
            end else begin
                if (blk_ready !== 1'b1 || busy !== 1'b0 || eoc !== 1'b0) begin
                    failures++;
                    $display("FAIL %s idle66: got rdy=%b busy=%b eoc=%b exp 1 0 0",
                             tag, blk_ready, busy, eoc);
                end
                checks++;
            end
            if (cyc < 66) step();
        end
        hash = comp_final();
        if (hash !== ABC_HASH) begin
            failures++;
            $display("FAIL %s hash: got %h exp %h", tag, hash, ABC_HASH);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int wait_cnt;
        logic [255:0] hash;
        comp_init();
        blk_in = ABC; blk_valid = 1'b1;
        step();
        for (int cyc = 1; cyc <= 66; cyc++) begin
            if (cyc <= 64) begin
                if (cyc <= 20 && wt !== gold[cyc-1]) begin
                    failures++;
                    $display("FAIL b2b wt t=%0d: got %h exp %h",
                             cyc - 1, wt, gold[cyc-1]);
                end
                if (cyc <= 20) checks++;
                comp_round(wt, kt);
            end
            if (cyc <= 65 && blk_ready !== 1'b0) begin
                failures++;
                $display("FAIL b2b ready c=%0d: got 1 exp 0", cyc);
            end
            if (cyc <= 65) checks++;
            if (cyc == 66 && blk_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b ready66: got %b exp 1", blk_ready);
            end
            if (cyc == 66) checks++;
            if (cyc == 10) blk_in = BLK_B;
            if (cyc < 66) step();
        end
        hash = comp_final();
        if (hash !== ABC_HASH) begin
            failures++;
            $display("FAIL b2b hash: got %h exp %h", hash, ABC_HASH);
        end
        checks++;
        step();
        if (soc !== 1'b1 || round !== 6'd0 || wt !== 32'hdeadbeef) begin
            failures++;
            $display("FAIL b2b second_soc: got soc=%b r=%0d wt=%h exp 1 0 deadbeef",
                     soc, round, wt);
        end
        checks++;
        blk_valid = 1'b0;
        step();
        if (soc !== 1'b0 || round !== 6'd1 || wt !== 32'h01234567) begin
            failures++;
            $display("FAIL b2b second_r1: got soc=%b r=%0d wt=%h exp 0 1 01234567",
                     soc, round, wt);
        end
        checks++;
        wait_cnt = 0;
        while (blk_ready !== 1'b1 && wait_cnt < 80) begin
            step();
            wait_cnt++;
        end
        if (blk_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b drain: got rdy=%b exp 1 within 80", blk_ready);
        end
        checks++;
    endtask

    task automatic test_reset_mid_run();
        int eoc_seen;
        blk_in = ABC; blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        for (int cyc = 1; cyc < 31; cyc++) step();
        if (round !== 6'd30 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst pre: got r=%0d busy=%b exp 30 1", round, busy);
        end
        checks++;
        #3;
        rst = 1'b1;
        #1;
        if ({wt, kt, round, soc, eoc, busy, blk_ready} !== 74'h0) begin
            failures++;
            $display("FAIL midrst async: got wt=%h kt=%h r=%0d soc=%b eoc=%b busy=%b rdy=%b",
                     wt, kt, round, soc, eoc, busy, blk_ready);
        end
        checks++;
        step();
        step();
        #3;
        rst = 1'b0;
        eoc_seen = 0;
        for (int c = 0; c < 70; c++) begin
            step();
            if (eoc === 1'b1 || busy === 1'b1) eoc_seen++;
        end
        if (eoc_seen !== 0) begin
            failures++;
            $display("FAIL midrst no_eoc: got %0d active cycles exp 0", eoc_seen);
        end
        checks++;
    endtask

    initial begin
        gold[0] = 32'h61626380;
        for (int i = 1; i < 15; i++) gold[i] = 32'h0;
        gold[15] = 32'h00000018;
        gold[16] = 32'h61626380;
        gold[17] = 32'h000f0000;
        gold[18] = 32'h7da86405;
        gold[19] = 32'h600003c6;

        test_reset();
        test_abc("abc");
        test_back_to_back();
        test_reset_mid_run();
        test_abc("abc_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- Message-schedule stage directly upstream of the SHA-256 compression round datapath.
- Accepts one padded 512-bit block through a valid/ready handshake.
- Streams Wt and the matching Kt for rounds t=0..63, one round per clock.
- Brackets each block with single-cycle soc and eoc strobes that drive the compression stage's control inputs.

Parameters:
- None. SHA-256 widths are fixed: 32-bit words, 512-bit block, 64 rounds.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- blk_in  input  512  padded message block, big-endian; W0 = blk_in[511:480], W15 = blk_in[31:0].
- blk_valid  input  1  blk_in is valid.
- blk_ready  output  1  block can be accepted this cycle.
- wt  output  32  schedule word for the current round.
- kt  output  32  round constant for the current round.
- round  output  6  current round index t.
- soc  output  1  start-of-computation strobe; high during round 0 only.
- eoc  output  1  end-of-computation strobe; high for one cycle after round 63.
- busy  output  1  high in RUN and DONE.

Behaviour:
- States: IDLE, RUN, DONE.
- Registers: 16x32 sliding window w[0..15], 6-bit round counter, state.
- Reset (asynchronous, any time, including mid-block):
  - state=IDLE, window=0, round=0.
  - wt=0, kt=0, soc=0, eoc=0, busy=0.
  - blk_ready=0 while rst is high.
  - A partially streamed block is discarded. No eoc is issued for it.
- blk_ready = (state==IDLE) && !rst. Combinational from state, no dependence on blk_valid.
- Accept: blk_valid && blk_ready at a rising edge.
  - Load w[i] from blk_in word i.
  - round <= 0.
  - state <= RUN.
  - blk_in is sampled only on the accept edge. Later changes are ignored.
- RUN, combinational outputs:
  - wt = w[0].
  - kt = K[round], from the standard 64-entry SHA-256 constant ROM (K0=0x428a2f98 ... K63=0xc67178f2).
  - soc = (round==0).
- RUN, each rising edge:
  - Window shifts: w[i] <= w[i+1] for i=0..14.
  - w[15] <= s1(w[14]) + w[9] + s0(w[1]) + w[0], mod 2^32, carries discarded.
  - s0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - round <= round+1.
- Round 63 → next edge: state <= DONE, round <= 0 (no 6-bit wrap into a new round 0 in RUN). Window update in this final step is don't-care.
- DONE: eoc=1 for exactly one cycle; wt=kt=0. Next edge → IDLE.
- Outside RUN: wt=0, kt=0, soc=0.
- Latency and throughput:
  - Round t is presented in cycle t+1 after the accept edge.
  - eoc appears in cycle 65.
  - blk_ready is high again in cycle 66, giving 66 cycles per block minimum.
- Simultaneous events:
  - blk_valid during RUN or DONE is ignored (ready=0). The upstream block must hold blk_in.
  - rst with blk_valid: reset wins, nothing is accepted.
- soc and eoc are never high in the same cycle. Exactly one soc and one eoc per completed block.

Test Plan:
- Reset values: assert rst for 3 cycles, with blk_valid=1 asynchronously mid-cycle.
  - → all outputs 0 and blk_ready=0 during reset.
  - → blk_ready=1 the cycle after release.
- "abc" block: W0=0x61626380, W1..W14=0, W15=0x00000018.
  - → round0 wt=0x61626380, kt=0x428a2f98, soc=1.
  - → wt at t=16..19 = 0x61626380, 0x000F0000, 0x7DA86405, 0x600003C6.
  - → round63 kt=0xc67178f2.
  - → eoc=1 exactly one cycle after round 63.
- Timing: count cycles from the accept edge.
  - → soc in cycle 1.
  - → round increments 0..63 monotonically.
  - → eoc in cycle 65, blk_ready high in cycle 66.
  - → busy high for cycles 1..65.
- Back-to-back: hold blk_valid=1 with two different blocks; change blk_in during RUN.
  - → the second block is accepted only in cycle 66.
  - → first-block wt values are unaffected by the change.
  - → the second soc follows in cycle 67.
- Reset mid-run: assert rst at round 30.
  - → outputs go to 0 immediately (asynchronous), no eoc is issued.
  - → the next accepted "abc" block reproduces the golden wt sequence.
- Compression integration: drive "abc" through this block into the compression stage.
  - → final hash = 0xba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
